param_vending_machine: RTL and testbench

//  Parametrised successor to the fixed nickel/dime vending FSM: configurable price and coin values,
//  a third coin (quarter), cancel/refund, and change return over a valid/ready handshake.

---
 rtl/vending_pkg.sv | 14 +
 rtl/coin_select.sv | 29 ++
 rtl/param_vending_machine.sv | 105 ++++++++++
 tb/tb_param_vending_machine.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding, default coin values and the illegal-state message.
package vending_pkg;
    typedef enum logic [1:0] {
        S_COLLECT  = 2'd0,
        S_DISPENSE = 2'd1,
        S_CHANGE   = 2'd2
    } state_t;
    localparam int DEF_PRICE       = 20;
    localparam int DEF_NICKEL_VAL  = 5;
    localparam int DEF_DIME_VAL    = 10;
    localparam int DEF_QUARTER_VAL = 25;
    localparam int DEF_CREDIT_W    = 6;
    localparam string ILLEGAL_STATE_MSG = "illegal state";
endpackage

// File: rtl/coin_select.sv
// coin_select: priority encoder picking at most one coin per cycle and flagging rejected coins.
// Ports: collect (machine is accepting coins), cancel, nickel/dime/quarter coin pulses;
//        accept (a coin is credited), value (its worth in cents), coin_reject (a coin is returned).
module coin_select
    import vending_pkg::*;
#(
    parameter int CREDIT_W    = DEF_CREDIT_W,
    parameter int NICKEL_VAL  = DEF_NICKEL_VAL,
    parameter int DIME_VAL    = DEF_DIME_VAL,
    parameter int QUARTER_VAL = DEF_QUARTER_VAL
) (
    input  logic                collect,
    input  logic                cancel,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    output logic                accept,
    output logic [CREDIT_W-1:0] value,
    output logic                coin_reject
);
    logic any_coin;
    logic multi_coin;
    assign any_coin   = nickel | dime | quarter;
    assign multi_coin = (quarter & (dime | nickel)) | (dime & nickel);
    assign accept     = collect & ~cancel & any_coin;
    assign value      = quarter ? CREDIT_W'(QUARTER_VAL) : dime ? CREDIT_W'(DIME_VAL) : CREDIT_W'(NICKEL_VAL);
    // Outside collection, or while cancelling, every coin goes back; otherwise only the losers do.
    assign coin_reject = (collect & ~cancel) ? multi_coin : any_coin;
endmodule

// File: rtl/param_vending_machine.sv
// param_vending_machine: parametrised vending FSM with cancel/refund and handshaked change return.
// Ports: clock, reset_n (sync, active-low); nickel/dime/quarter coin pulses; cancel;
//        dispense (1-cycle release pulse); coin_reject (comb, coin returned this cycle);
//        change_valid/change_ready (one NICKEL_VAL coin per handshake); credit; busy.
module param_vending_machine
    import vending_pkg::*;
#(
    parameter int PRICE       = DEF_PRICE,
    parameter int NICKEL_VAL  = DEF_NICKEL_VAL,
    parameter int DIME_VAL    = DEF_DIME_VAL,
    parameter int QUARTER_VAL = DEF_QUARTER_VAL,
    parameter int CREDIT_W    = DEF_CREDIT_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic                dispense,
    output logic                coin_reject,
    output logic                change_valid,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(NICKEL_VAL);

    // Worst case credit is one nickel short of the price plus a quarter.
    if (PRICE <= 0 || PRICE % NICKEL_VAL != 0 || DIME_VAL % NICKEL_VAL != 0 ||
        QUARTER_VAL % NICKEL_VAL != 0 ||
        (PRICE - NICKEL_VAL + QUARTER_VAL) >= (1 << CREDIT_W)) begin : g_param_check
        $error("param_vending_machine: illegal parameter set");
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                accept;
    logic [CREDIT_W-1:0] value;
    logic [CREDIT_W-1:0] cn;

    coin_select #(
        .CREDIT_W    (CREDIT_W),
        .NICKEL_VAL  (NICKEL_VAL),
        .DIME_VAL    (DIME_VAL),
        .QUARTER_VAL (QUARTER_VAL)
    ) u_coin_select (
        .collect     (state_q == S_COLLECT),
        .cancel      (cancel),
        .nickel      (nickel),
        .dime        (dime),
        .quarter     (quarter),
        .accept      (accept),
        .value       (value),
        .coin_reject (coin_reject)
    );

    assign cn = credit_q + value;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        case (state_q)
            S_COLLECT: begin
                if (cancel) begin
                    state_d = (credit_q != '0) ? S_CHANGE : S_COLLECT;
                end else if (accept) begin
                    state_d  = (cn >= PRICE_C) ? S_DISPENSE : S_COLLECT;
                    credit_d = (cn >= PRICE_C) ? cn - PRICE_C : cn;
                end
            end
            S_DISPENSE: state_d = (credit_q != '0) ? S_CHANGE : S_COLLECT;
            S_CHANGE: begin
                if (credit_q == '0) begin
                    state_d = S_COLLECT;
                end else if (change_ready) begin
                    credit_d = credit_q - NICKEL_C;
                    state_d  = (credit_q == NICKEL_C) ? S_COLLECT : S_CHANGE;
                end
            end
            default: begin
                state_d  = S_COLLECT;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        assert (!reset_n || state_q inside {S_COLLECT, S_DISPENSE, S_CHANGE})
            else $error("%s", ILLEGAL_STATE_MSG);
        if (!reset_n) begin
            state_q  <= S_COLLECT;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    assign dispense     = (state_q == S_DISPENSE);
    assign change_valid = (state_q == S_CHANGE) && (credit_q != '0);
    assign credit       = credit_q;
    assign busy         = (state_q != S_COLLECT);
endmodule

// File: tb/tb_param_vending_machine.sv
// tb_param_vending_machine: directed scenarios against hand-computed expectations, PRICE=20.
module tb_param_vending_machine;
    logic       clock = 1'b0;
    logic       reset_n, nickel, dime, quarter, cancel, change_ready;
    logic       dispense, coin_reject, change_valid, busy;
    logic [5:0] credit;
    int         tests = 0;
    int         fails = 0;

    param_vending_machine dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .nickel       (nickel),
        .dime         (dime),
        .quarter      (quarter),
        .cancel       (cancel),
        .dispense     (dispense),
        .coin_reject  (coin_reject),
        .change_valid (change_valid),
        .change_ready (change_ready),
        .credit       (credit),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic coin(input logic n, input logic d, input logic q);
        nickel = n; dime = d; quarter = q;
        step();
        nickel = 0; dime = 0; quarter = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; nickel = 0; dime = 0; quarter = 0; cancel = 0; change_ready = 0;
        step(); step();
        reset_n = 1;
        tests++; if (credit !== 6'd0) begin fails++; $display("FAIL reset_credit got %0d exp 0", credit); end
        tests++; if ({dispense, change_valid, busy} !== 3'b000) begin fails++; $display("FAIL reset_outputs got %b exp 000", {dispense, change_valid, busy}); end
    endtask

    task automatic test_exact_price();
        coin(1, 0, 0);
        tests++; if (credit !== 6'd5) begin fails++; $display("FAIL exact_n1 got %0d exp 5", credit); end
        coin(1, 0, 0);
        tests++; if (credit !== 6'd10) begin fails++; $display("FAIL exact_n2 got %0d exp 10", credit); end
        coin(0, 1, 0);
        tests++; if ({dispense, change_valid, busy} !== 3'b101) begin fails++; $display("FAIL exact_dispense got %b exp 101", {dispense, change_valid, busy}); end
        tests++; if (credit !== 6'd0) begin fails++; $display("FAIL exact_credit got %0d exp 0", credit); end
        step();
        tests++; if ({dispense, change_valid, busy} !== 3'b000) begin fails++; $display("FAIL exact_idle got %b exp 000", {dispense, change_valid, busy}); end
    endtask

    task automatic test_quarter_change();
        coin(0, 0, 1);
        tests++; if ({dispense, change_valid} !== 2'b10 || credit !== 6'd5) begin fails++; $display("FAIL quarter_dispense got %b/%0d exp 10/5", {dispense, change_valid}, credit); end
        step();
        tests++; if ({dispense, change_valid, busy} !== 3'b011 || credit !== 6'd5) begin fails++; $display("FAIL quarter_change got %b/%0d exp 011/5", {dispense, change_valid, busy}, credit); end
        change_ready = 1;
        step();
        change_ready = 0;
        tests++; if ({change_valid, busy} !== 2'b00 || credit !== 6'd0) begin fails++; $display("FAIL quarter_done got %b/%0d exp 00/0", {change_valid, busy}, credit); end
    endtask

    task automatic test_cancel_refund();
        coin(0, 1, 0);
        coin(1, 0, 0);
        tests++; if (credit !== 6'd15) begin fails++; $display("FAIL cancel_credit got %0d exp 15", credit); end
        cancel = 1; step(); cancel = 0;
        for (int i = 0; i < 4; i++) begin
            tests++; if ({dispense, change_valid, busy} !== 3'b011 || credit !== 6'd15) begin fails++; $display("FAIL cancel_hold%0d got %b/%0d exp 011/15", i, {dispense, change_valid, busy}, credit); end
            if (i < 3) step();
        end
        change_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (credit !== 6'(10 - 5 * i) || dispense !== 1'b0) begin fails++; $display("FAIL cancel_refund%0d got %0d/%b exp %0d/0", i, credit, dispense, 10 - 5 * i); end
        end
        change_ready = 0;
        tests++; if ({change_valid, busy} !== 2'b00) begin fails++; $display("FAIL cancel_idle got %b exp 00", {change_valid, busy}); end
    endtask

    task automatic test_multi_coin();
        dime = 1; nickel = 1; #1;
        tests++; if (coin_reject !== 1'b1) begin fails++; $display("FAIL multi_reject got %b exp 1", coin_reject); end
        step(); dime = 0; nickel = 0;
        tests++; if (credit !== 6'd10) begin fails++; $display("FAIL multi_dime got %0d exp 10", credit); end
        nickel = 1; #1;
        tests++; if (coin_reject !== 1'b0) begin fails++; $display("FAIL single_noreject got %b exp 0", coin_reject); end
        step(); nickel = 0;
        coin(0, 1, 0);
        tests++; if (dispense !== 1'b1 || credit !== 6'd5) begin fails++; $display("FAIL multi_disp got %b/%0d exp 1/5", dispense, credit); end
        nickel = 1; #1;
        tests++; if (coin_reject !== 1'b1) begin fails++; $display("FAIL disp_reject got %b exp 1", coin_reject); end
        step(); nickel = 0;
        tests++; if (credit !== 6'd5 || change_valid !== 1'b1) begin fails++; $display("FAIL disp_credit got %0d/%b exp 5/1", credit, change_valid); end
        change_ready = 1; step(); change_ready = 0;
        quarter = 1; dime = 1; nickel = 1; #1;
        tests++; if (coin_reject !== 1'b1) begin fails++; $display("FAIL prio_reject got %b exp 1", coin_reject); end
        step(); quarter = 0; dime = 0; nickel = 0;
        tests++; if (dispense !== 1'b1 || credit !== 6'd5) begin fails++; $display("FAIL prio_quarter got %b/%0d exp 1/5", dispense, credit); end
        step(); change_ready = 1; step(); change_ready = 0;
        tests++; if (credit !== 6'd0 || busy !== 1'b0) begin fails++; $display("FAIL prio_drain got %0d/%b exp 0/0", credit, busy); end
    endtask

    task automatic test_reset_mid_change();
        coin(0, 0, 1);
        coin(0, 0, 1);
        tests++; if (change_valid !== 1'b1 || credit !== 6'd5) begin fails++; $display("FAIL rst_pre got %b/%0d exp 1/5", change_valid, credit); end
        reset_n = 0; change_ready = 1; step(); reset_n = 1; change_ready = 0;
        tests++; if (credit !== 6'd0 || {dispense, change_valid, busy, coin_reject} !== 4'b0000) begin fails++; $display("FAIL rst_mid got %0d/%b exp 0/0000", credit, {dispense, change_valid, busy, coin_reject}); end
        step();
        tests++; if (busy !== 1'b0 || change_valid !== 1'b0) begin fails++; $display("FAIL rst_after got %b%b exp 00", busy, change_valid); end
    endtask

    task automatic test_cancel_zero();
        cancel = 1; step();
        tests++; if ({busy, change_valid} !== 2'b00 || credit !== 6'd0) begin fails++; $display("FAIL cancel0 got %b/%0d exp 00/0", {busy, change_valid}, credit); end
        nickel = 1; #1;
        tests++; if (coin_reject !== 1'b1) begin fails++; $display("FAIL cancel_nickel_rej got %b exp 1", coin_reject); end
        step(); nickel = 0; cancel = 0;
        tests++; if (credit !== 6'd0 || busy !== 1'b0) begin fails++; $display("FAIL cancel_nickel got %0d/%b exp 0/0", credit, busy); end
        coin(1, 0, 0);
        cancel = 1; quarter = 1; #1;
        tests++; if (coin_reject !== 1'b1) begin fails++; $display("FAIL cancel_q_rej got %b exp 1", coin_reject); end
        step(); cancel = 0; quarter = 0;
        tests++; if (change_valid !== 1'b1 || credit !== 6'd5) begin fails++; $display("FAIL cancel_q got %b/%0d exp 1/5", change_valid, credit); end
        change_ready = 1; step(); change_ready = 0;
        tests++; if (credit !== 6'd0 || busy !== 1'b0) begin fails++; $display("FAIL cancel_q_done got %0d/%b exp 0/0", credit, busy); end
    endtask

    task automatic test_back_to_back();
        coin(0, 1, 0);
        coin(0, 1, 0);
        tests++; if (dispense !== 1'b1 || credit !== 6'd0) begin fails++; $display("FAIL b2b_first got %b/%0d exp 1/0", dispense, credit); end
        coin(0, 1, 0);
        tests++; if (dispense !== 1'b0 || credit !== 6'd0) begin fails++; $display("FAIL b2b_lost got %b/%0d exp 0/0", dispense, credit); end
        coin(0, 1, 0);
        coin(0, 1, 0);
        tests++; if (dispense !== 1'b1 || credit !== 6'd0) begin fails++; $display("FAIL b2b_second got %b/%0d exp 1/0", dispense, credit); end
        step();
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_quarter_change();
        test_cancel_refund();
        test_multi_coin();
        test_reset_mid_change();
        test_cancel_zero();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
